// File: rtl/fir_filter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fir_filter : N-tap direct-form FIR, scaled by P fraction bits and saturated
// Revision   : 1.0
// ---------------------------------------------------------------------------
module fir_filter #(
   parameter int BITWIDTH = 16,
   parameter int ACCWIDTH = 24,
   parameter int N        = 16,
   parameter int P        = 0
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       enable,
   input  logic signed [BITWIDTH-1:0] cs [N],
   input  logic signed [BITWIDTH-1:0] inP,
   output logic signed [BITWIDTH-1:0] outP,
   output logic                       out_enable
);

   localparam int PW = 2 * BITWIDTH;
   localparam logic signed [BITWIDTH-1:0] OUT_MAX = {1'b0, {(BITWIDTH-1){1'b1}}};
   localparam logic signed [BITWIDTH-1:0] OUT_MIN = {1'b1, {(BITWIDTH-1){1'b0}}};
   localparam logic signed [ACCWIDTH-1:0] ACC_MAX = ACCWIDTH'(OUT_MAX);
   localparam logic signed [ACCWIDTH-1:0] ACC_MIN = ACCWIDTH'(OUT_MIN);

   logic signed [BITWIDTH-1:0] zs    [N];
   logic signed [PW-1:0]       mults [N];
   logic signed [ACCWIDTH-1:0] acc;
   logic signed [ACCWIDTH-1:0] shifted;
   logic signed [BITWIDTH-1:0] sat;
   logic                       en_d;

   generate
      for (genvar k = 0; k < N; k++) begin : g_mult
         assign mults[k] = PW'(cs[k]) * PW'(zs[k]);
      end
   endgenerate

   // Accumulation is modulo 2^ACCWIDTH; overflow wraps silently.
   always_comb begin
      acc = '0;
      for (int k = 0; k < N; k++) begin
         acc = acc + ACCWIDTH'(mults[k]);
      end
      shifted = acc >>> P;
      if (shifted > ACC_MAX) begin
         sat = OUT_MAX;
      end else if (shifted < ACC_MIN) begin
         sat = OUT_MIN;
      end else begin
         sat = shifted[BITWIDTH-1:0];
      end
   end

   always_ff @(posedge clk or posedge resetn) begin
      if (resetn) begin
         for (int k = 0; k < N; k++) begin
            zs[k] <= '0;
         end
      end else if (enable) begin
         zs[0] <= inP;
         for (int k = 1; k < N; k++) begin
            zs[k] <= zs[k-1];
         end
      end
   end

   always_ff @(posedge clk or posedge resetn) begin
      if (resetn) begin
         en_d       <= 1'b0;
         outP       <= '0;
         out_enable <= 1'b0;
      end else begin
         en_d       <= enable;
         out_enable <= en_d;
         if (en_d) begin
            outP <= sat;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fir_filter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fir_filter : scoreboard bench for fir_filter, P=0 and P=4 side by side
// Revision      : 1.0
// ---------------------------------------------------------------------------
module tb_fir_filter;

   localparam int NT = 16;

   logic                clk = 1'b0;
   logic                resetn;
   logic                enable;
   logic signed [15:0]  cs [NT];
   logic signed [15:0]  inP;
   logic signed [15:0]  out0, out4;
   logic                oe0, oe4;

   int passed = 0;
   int total  = 0;

   int                 zm [NT];
   logic signed [15:0] q0 [$];
   logic signed [15:0] q4 [$];
   logic               prev_en;
   logic signed [15:0] last0, last4;

   always #5 clk = ~clk;

   fir_filter #(.BITWIDTH(16), .ACCWIDTH(24), .N(NT), .P(0)) dut0 (
      .clk(clk), .resetn(resetn), .enable(enable), .cs(cs), .inP(inP),
      .outP(out0), .out_enable(oe0)
   );

   fir_filter #(.BITWIDTH(16), .ACCWIDTH(24), .N(NT), .P(4)) dut4 (
      .clk(clk), .resetn(resetn), .enable(enable), .cs(cs), .inP(inP),
      .outP(out4), .out_enable(oe4)
   );

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   // Reference: exact sum, wrap to 24 bits, arithmetic shift, clamp.
   function automatic logic signed [15:0] model_out(input int p);
      longint             s;
      logic [63:0]        su;
      logic signed [23:0] a;
      int                 v;
      s = 0;
      for (int k = 0; k < NT; k++) s += longint'(cs[k]) * longint'(zm[k]);
      su = s;
      a  = su[23:0];
      v  = int'(a) >>> p;
      if (v > 32767)       return 16'sh7fff;
      else if (v < -32768) return 16'sh8000;
      else                 return 16'(v);
   endfunction

   task automatic step(input logic en, input logic signed [15:0] x);
      logic signed [15:0] e;
      enable = en;
      inP    = x;
      if (en) begin
         for (int k = NT-1; k > 0; k--) zm[k] = zm[k-1];
         zm[0] = int'(x);
         q0.push_back(model_out(0));
         q4.push_back(model_out(4));
      end
      @(posedge clk);
      #1;
      chk("out_enable_p0", 32'(oe0), 32'(prev_en));
      chk("out_enable_p4", 32'(oe4), 32'(prev_en));
      if (oe0) begin
         chk("queue_p0_nonempty", 32'(q0.size() != 0), 32'd1);
         if (q0.size() != 0) begin
            e = q0.pop_front();
            chk("outP_p0", out0, e);
         end
      end else begin
         chk("hold_p0", out0, last0);
      end
      if (oe4) begin
         chk("queue_p4_nonempty", 32'(q4.size() != 0), 32'd1);
         if (q4.size() != 0) begin
            e = q4.pop_front();
            chk("outP_p4", out4, e);
         end
      end else begin
         chk("hold_p4", out4, last4);
      end
      last0   = out0;
      last4   = out4;
      prev_en = en;
   endtask

   task automatic run(input int n, input logic en, input logic signed [15:0] x);
      for (int i = 0; i < n; i++) step(en, x);
   endtask

   initial begin
      resetn  = 1'b1;
      enable  = 1'b0;
      inP     = '0;
      prev_en = 1'b0;
      last0   = '0;
      last4   = '0;
      for (int k = 0; k < NT; k++) begin
         cs[k] = 16'(k);
         zm[k] = 0;
      end
      @(posedge clk);
      #1;
      chk("reset_outP", out0, 0);
      chk("reset_out_enable", 32'(oe0), 0);
      @(posedge clk);
      #1;
      resetn = 1'b0;
      for (int i = 0; i < 5; i++) step(1'b0, 16'($urandom));

      // Impulse: outputs 0,1,..,15 then zeros
      step(1'b1, 16'sd1);
      run(20, 1'b1, 16'sd0);
      run(2, 1'b0, 16'sd0);

      // Step: ramps to 120
      run(20, 1'b1, 16'sd1);
      chk("step_steady", last0, 120);
      chk("step_steady_p4", last4, 7);

      // Mid-stream asynchronous reset
      run(3, 1'b1, 16'sd5);
      #3;
      resetn = 1'b1;
      #1;
      chk("async_reset_outP", out0, 0);
      chk("async_reset_out_enable", 32'(oe0), 0);
      chk("async_reset_outP_p4", out4, 0);
      q0.delete();
      q4.delete();
      for (int k = 0; k < NT; k++) zm[k] = 0;
      prev_en = 1'b0;
      last0   = '0;
      last4   = '0;
      @(posedge clk);
      #1;
      resetn = 1'b0;
      for (int i = 0; i < 5; i++) step(1'b0, 16'($urandom));

      // Post-reset impulse proves the delay line was flushed
      step(1'b1, 16'sd1);
      run(17, 1'b1, 16'sd0);
      run(2, 1'b0, 16'sd0);

      // Saturation
      run(20, 1'b1, 16'sd32767);
      chk("sat_pos", last0, 32767);
      run(20, 1'b1, -16'sd32768);
      chk("sat_neg", last0, -32768);
      run(2, 1'b0, 16'sd0);

      // Enable gaps: impulse with alternating enable, random data when idle
      run(16, 1'b1, 16'sd0);
      step(1'b1, 16'sd1);
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 16'($urandom));
         step(1'b1, 16'sd0);
      end
      run(3, 1'b0, 16'sd0);

      // Fractional scaling
      run(20, 1'b1, 16'sd16);
      chk("frac_pos_p4", last4, 120);
      chk("frac_pos_p0", last0, 1920);
      run(20, 1'b1, -16'sd16);
      chk("frac_neg_p4", last4, -120);
      run(3, 1'b0, 16'sd0);

      // Runtime coefficient change: all ones gives running sum of 16
      for (int k = 0; k < NT; k++) cs[k] = 16'sd1;
      run(20, 1'b1, 16'sd3);
      chk("coef_change", last0, 48);
      run(3, 1'b0, 16'sd0);

      chk("scoreboard_drained", 32'(q0.size() + q4.size()), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
